// File: rtl/face_event_display_if.sv
// Event and face-display bundle between game-state logic and the segment mux.
// The slave side belongs to face_event_display; the master side is the game logic / mux.
interface face_event_display_if;
    logic       newHighScore;
    logic       died;
    logic       timeout;
    logic       timer_enable;
    logic [6:0] eyes;
    logic [6:0] mouth;
    logic       showFace;
    logic [1:0] face_id;

    modport master (
        output newHighScore, died, timeout,
        input  timer_enable, eyes, mouth, showFace, face_id
    );

    modport slave (
        input  newHighScore, died, timeout,
        output timer_enable, eyes, mouth, showFace, face_id
    );
endinterface

// File: rtl/face_event_display.sv
// Happy/sad face sequencer with one-deep pending latches; define FACE_BLINK_EN for blinking faces.
// Latency 1 clk from event to face; no backpressure, events are level-sampled and latched one deep.
module face_event_display #(
    parameter int HOLD_TICKS = 2,
    parameter int CNT_W      = 3,
    parameter bit PREEMPT    = 1'b1,
    parameter bit RETRIGGER  = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    face_event_display_if.slave  bus
);

    typedef enum logic [1:0] {IDLE = 2'd0, SHOW = 2'd1, GAP = 2'd2} state_t;
    typedef enum logic [1:0] {FACE_NONE = 2'd0, FACE_HAPPY = 2'd1, FACE_SAD = 2'd2} face_t;

    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(HOLD_TICKS - 1);
    localparam logic [6:0]       SEG_BLANK = 7'b1111111;
    localparam logic [6:0]       SEG_EYES  = 7'b1110110;
    localparam logic [6:0]       SEG_SMILE = 7'b1110000;
    localparam logic [6:0]       SEG_FROWN = 7'b1000110;

    state_t           state, state_n;
    face_t            face, face_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             pend_h, pend_h_n;
    logic             pend_s, pend_s_n;
    logic             req_h, req_s;

    logic             timer_enable_n, show_face_n;
    logic [1:0]       face_id_n;
    logic [6:0]       eyes_n, mouth_n;

    assign req_h = bus.newHighScore | pend_h;
    assign req_s = bus.died | pend_s;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            face   <= FACE_NONE;
            cnt    <= '0;
            pend_h <= 1'b0;
            pend_s <= 1'b0;
        end else begin
            state  <= state_n;
            face   <= face_n;
            cnt    <= cnt_n;
            pend_h <= pend_h_n;
            pend_s <= pend_s_n;
        end
    end

    always_comb begin
        state_n  = state;
        face_n   = face;
        cnt_n    = cnt;
        pend_h_n = pend_h;
        pend_s_n = pend_s;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (req_h) begin
                    state_n  = SHOW;
                    face_n   = FACE_HAPPY;
                    pend_h_n = 1'b0;
                    pend_s_n = pend_s | bus.died;
                end else if (req_s) begin
                    state_n  = SHOW;
                    face_n   = FACE_SAD;
                    pend_s_n = 1'b0;
                end
            end
            SHOW: begin
                if (bus.timeout) begin
                    if (cnt == LAST_CNT) begin
                        state_n = GAP;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                // Restart and preemption override a simultaneous terminal timeout.
                if (face == FACE_HAPPY) begin
                    if (bus.died) pend_s_n = 1'b1;
                    if (bus.newHighScore && RETRIGGER) begin
                        state_n = SHOW;
                        cnt_n   = '0;
                    end
                end else if (bus.newHighScore && PREEMPT) begin
                    state_n = SHOW;
                    face_n  = FACE_HAPPY;
                    cnt_n   = '0;
                end else begin
                    if (bus.newHighScore) pend_h_n = 1'b1;
                    if (bus.died && RETRIGGER) begin
                        state_n = SHOW;
                        cnt_n   = '0;
                    end
                end
            end
            GAP: begin
                state_n  = IDLE;
                cnt_n    = '0;
                pend_h_n = pend_h | bus.newHighScore;
                pend_s_n = pend_s | bus.died;
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_comb begin
        timer_enable_n = 1'b0;
        show_face_n    = 1'b0;
        face_id_n      = 2'd0;
        eyes_n         = SEG_BLANK;
        mouth_n        = SEG_BLANK;
        if (state_n == SHOW) begin
            timer_enable_n = 1'b1;
`ifdef FACE_BLINK_EN
            show_face_n    = ~cnt_n[0];
`else
            show_face_n    = 1'b1;
`endif
            face_id_n      = face_n;
            eyes_n         = SEG_EYES;
            mouth_n        = (face_n == FACE_HAPPY) ? SEG_SMILE : SEG_FROWN;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.timer_enable <= 1'b0;
            bus.showFace     <= 1'b0;
            bus.face_id      <= 2'd0;
            bus.eyes         <= SEG_BLANK;
            bus.mouth        <= SEG_BLANK;
        end else begin
            bus.timer_enable <= timer_enable_n;
            bus.showFace     <= show_face_n;
            bus.face_id      <= face_id_n;
            bus.eyes         <= eyes_n;
            bus.mouth        <= mouth_n;
        end
    end

endmodule

// File: tb/tb_face_event_display.sv
// Randomised and directed bench for face_event_display, two parameter sets side by side.
module tb_face_event_display;

    localparam logic [17:0] BLANK = {4'b0000, 7'b1111111, 7'b1111111};

    logic clk;
    logic rst;
    logic nh, dd, to;
    int   n_checks;
    int   n_errors;

    face_event_display_if bus0();
    face_event_display_if bus1();

    assign bus0.newHighScore = nh;
    assign bus0.died         = dd;
    assign bus0.timeout      = to;
    assign bus1.newHighScore = nh;
    assign bus1.died         = dd;
    assign bus1.timeout      = to;

    face_event_display #(.HOLD_TICKS(2), .CNT_W(3), .PREEMPT(1'b1), .RETRIGGER(1'b1)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0.slave)
    );

    face_event_display #(.HOLD_TICKS(3), .CNT_W(3), .PREEMPT(1'b0), .RETRIGGER(1'b0)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: face on display (0 none, 1 happy, 2 sad), ticks left before it drops.
    int hold_p [2] = '{2, 3};
    bit pre_p  [2] = '{1'b1, 1'b0};
    bit rtg_p  [2] = '{1'b1, 1'b0};
    int m_face [2];
    int m_left [2];
    bit m_gap  [2];
    bit m_ph   [2];
    bit m_ps   [2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_face[i] = 0;
            m_left[i] = 0;
            m_gap[i]  = 1'b0;
            m_ph[i]   = 1'b0;
            m_ps[i]   = 1'b0;
        end
    endtask

    task automatic model_step(input int i, input bit e_h, input bit e_s, input bit e_t);
        bit restart;
        restart = 1'b0;
        if (m_gap[i]) begin
            m_gap[i] = 1'b0;
            if (e_h) m_ph[i] = 1'b1;
            if (e_s) m_ps[i] = 1'b1;
        end else if (m_face[i] == 0) begin
            if (e_h || m_ph[i]) begin
                m_face[i] = 1;
                m_left[i] = hold_p[i];
                m_ph[i]   = 1'b0;
                if (e_s) m_ps[i] = 1'b1;
            end else if (e_s || m_ps[i]) begin
                m_face[i] = 2;
                m_left[i] = hold_p[i];
                m_ps[i]   = 1'b0;
            end
        end else if (m_face[i] == 2 && e_h && pre_p[i]) begin
            m_face[i] = 1;
            m_left[i] = hold_p[i];
        end else begin
            if (m_face[i] == 1) begin
                if (e_s) m_ps[i] = 1'b1;
                restart = e_h && rtg_p[i];
            end else begin
                if (e_h) m_ph[i] = 1'b1;
                restart = e_s && rtg_p[i];
            end
            if (restart) begin
                m_left[i] = hold_p[i];
            end else if (e_t) begin
                m_left[i] = m_left[i] - 1;
                if (m_left[i] == 0) begin
                    m_face[i] = 0;
                    m_gap[i]  = 1'b1;
                end
            end
        end
    endtask

    function automatic logic [17:0] expect_out(input int i);
        logic sf;
        if (m_face[i] == 0) return BLANK;
        sf = 1'b1;
`ifdef FACE_BLINK_EN
        sf = (((hold_p[i] - m_left[i]) % 2) == 0);
`endif
        return {1'b1, sf, 2'(m_face[i]), 7'b1110110,
                (m_face[i] == 1) ? 7'b1110000 : 7'b1000110};
    endfunction

    function automatic logic [17:0] obs0();
        return {bus0.timer_enable, bus0.showFace, bus0.face_id, bus0.eyes, bus0.mouth};
    endfunction

    function automatic logic [17:0] obs1();
        return {bus1.timer_enable, bus1.showFace, bus1.face_id, bus1.eyes, bus1.mouth};
    endfunction

    task automatic cycle(input bit e_h, input bit e_s, input bit e_t);
        nh = e_h;
        dd = e_s;
        to = e_t;
        @(posedge clk);
        model_step(0, e_h, e_s, e_t);
        model_step(1, e_h, e_s, e_t);
        @(negedge clk);
        check("dut0_outputs", 32'(obs0()), 32'(expect_out(0)));
        check("dut1_outputs", 32'(obs1()), 32'(expect_out(1)));
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        nh = 1'b0;
        dd = 1'b0;
        to = 1'b0;
        rst = 1'b1;
        model_reset();
        #1 rst = 1'b0;
        #12;
        check("reset_dut0", 32'(obs0()), 32'(BLANK));
        check("reset_dut1", 32'(obs1()), 32'(BLANK));
        @(negedge clk);
        rst = 1'b1;

        // Single happy event, held for the hold count, then gap and idle.
        cycle(1'b1, 1'b0, 1'b0);
        check("happy_id", 32'(bus0.face_id), 32'd1);
        check("happy_mouth", 32'(bus0.mouth), 32'(7'b1110000));
        check("happy_show", 32'(bus0.showFace), 32'd1);
        cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b1);
        check("gap_after_hold", 32'(bus0.timer_enable), 32'd0);
        repeat (4) cycle(1'b0, 1'b0, 1'b1);

        // Simultaneous events: happy first, sad afterwards.
        cycle(1'b1, 1'b1, 1'b0);
        check("both_happy_first", 32'(bus0.face_id), 32'd1);
        repeat (10) cycle(1'b0, 1'b0, 1'b1);

        // Sad interrupted by a high score after one tick.
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 1'b0);
        check("preempt_on", 32'(bus0.face_id), 32'd1);
        check("preempt_off", 32'(bus1.face_id), 32'd2);
        repeat (12) cycle(1'b0, 1'b0, 1'b1);

        // Same-type event while shown.
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1);
        check("retrigger_still_up", 32'(bus0.face_id), 32'd1);
        repeat (8) cycle(1'b0, 1'b0, 1'b1);

        // Asynchronous reset in the middle of a face, with a sad pending.
        cycle(1'b1, 1'b1, 1'b0);
        #2 rst = 1'b0;
        #1;
        check("async_rst_dut0", 32'(obs0()), 32'(BLANK));
        check("async_rst_dut1", 32'(obs1()), 32'(BLANK));
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) cycle(1'b0, 1'b0, 1'b1);
        check("no_pending_after_rst", 32'(bus0.face_id), 32'd0);

        repeat (4000) begin
            cycle(($urandom % 8) == 0, ($urandom % 8) == 0, ($urandom % 3) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
